bounce_gen: RTL
===============

# bounce_gen

Synthesizable contact-bounce emulator: the driving end of the `debounce` input path. A clean level on `in` becomes a realistic noisy waveform on `out`. `out` toggles at pseudo-random intervals for a fixed window, then settles to the requested level and holds it. The block feeds `debounce` on-board for self-test and in benches, so debouncer behaviour is exercised against repeatable, deterministic bounce patterns.

## Interface
- SETTLE_CYC, 400, length of the bounce window in cycles (≥ 2)
- HOLD_CYC, 100, guaranteed stable time after settling, in cycles (≥ 1)
- GAP_W, 4, width of the random gap field; gap between toggles is 1..2^GAP_W cycles
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in  input  1  clean requested level (button model)
- out  output  1  bouncy emulated contact signal, to `debounce.in`
- busy  output  1  high in BOUNCE and HOLD
- done  output  1  one-cycle pulse when HOLD completes

## Operation
- State machine, states IDLE, BOUNCE and HOLD.
- Registers:
  - `target`, the latched requested level.
  - `win_cnt`, the bounce window countdown, width ≥ clog2(SETTLE_CYC+1).
  - `gap_cnt`, width GAP_W+1.
  - `hold_cnt`.
  - `lfsr[15:0]`.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle that reset is low, in every state.
  - Never reaches zero.
- Gap reload value is lfsr[GAP_W-1:0] + 1, using the LFSR value before that edge's advance.
- IDLE, exit condition: `in != out` → BOUNCE on the same edge.
  - `target` ← `in`, `win_cnt` ← SETTLE_CYC-1, `out` ← ~`out`, `gap_cnt` ← gap reload.
- IDLE, otherwise: `out` holds, `busy`=0.
- BOUNCE, each cycle:
  - If `win_cnt`==0: `out` ← `target`, `hold_cnt` ← HOLD_CYC-1, → HOLD.
  - Else if `gap_cnt`==1: `out` ← ~`out`, `gap_cnt` ← reload, `win_cnt` decrements.
  - Else: `gap_cnt` and `win_cnt` decrement.
- BOUNCE, `in` changes (`in != target`) while `win_cnt`≠0:
  - `target` ← `in` and `win_cnt` ← SETTLE_CYC-1 (window restarts).
  - The gap logic continues unchanged that cycle.
  - This event takes priority over the `win_cnt` decrement.
- HOLD:
  - `out` fixed at `target`; changes on `in` are ignored.
  - At `hold_cnt`==0: `done` ← 1 for one cycle, `busy` ← 0, → IDLE.
  - Otherwise `hold_cnt` decrements.
- Back in IDLE, an `in` that differs from `out` (including one that changed during HOLD) starts a new BOUNCE on the next edge.
- Reset, at any point including mid-BOUNCE or mid-HOLD:
  - `out`=0, `busy`=0, `done`=0, `target`=0, state IDLE, counters 0.
  - `lfsr`=LFSR_SEED (or 1 if the seed is 0).
- Determinism: identical stimulus after reset yields a bit-identical `out` waveform.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0.
- Entry edge E: the first rising edge where `in` differs from `out` in IDLE.
  - `busy`=1 and `out` toggles at E.
- Toggles within the window occur at intervals of 1..2^GAP_W cycles.
- `out`==`target` is guaranteed from edge E+SETTLE_CYC.
- `out` is then stable through edge E+SETTLE_CYC+HOLD_CYC.
- `done`=1 and `busy`=0 at edge E+SETTLE_CYC+HOLD_CYC.
  - `done` is low again on the following edge.
- Earliest next entry is edge E+SETTLE_CYC+HOLD_CYC+1.
- A mid-window `in` change at edge R moves settling to R+SETTLE_CYC.
- No combinational path from `in` to `out`; all outputs are registered.

## Test plan
- Reset: hold `reset`=1 for one edge with `in`=1 → `out`=0, `busy`=0, `done`=0 at that edge; BOUNCE entry follows on the next edge.
- Rising request (SETTLE_CYC=40, HOLD_CYC=8, GAP_W=3):
  - Stimulus: `in` 0→1 at a negedge, entry edge E.
  - `out` toggles at E, and consecutive toggles are spaced 1–8 cycles.
  - `out`=1 from E+40; `done` pulses only at E+48; `busy` is high E..E+47 and low at E+48.
- Window restart, same parameters:
  - Stimulus: `in` 0→1, then back to 0 at E+10.
  - `out`=0 from E+50; `done` pulses at E+58; no `done` at E+48.
- HOLD ignores input, same parameters:
  - Stimulus: `in` 1→0 at E+42, during HOLD.
  - `out` stays 1 through E+48.
  - New entry at E+49 with `out` toggling to 0; `done` pulses at E+97.
- Mid-operation reset and determinism:
  - Stimulus: reset at E+20, then repeat the rising-request stimulus.
  - `out` is 0 on the reset edge.
  - The second run's `out` trace equals the first run's cycle-for-cycle.
- Loopback with `debounce` (`out` → `debounce.in`, same clock and reset):
  - Stimulus: one 0→1 request.
  - `p_out` pulses exactly once, after `out` settles.
  - No `p_out` pulse during the bounce window.

Source files
------------

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: turns a clean requested level into a deterministic
// noisy waveform, then settles and holds the requested level for a fixed time.
module bounce_gen #(
  parameter int unsigned SETTLE_CYC = 400,
  parameter int unsigned HOLD_CYC   = 100,
  parameter int unsigned GAP_W      = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic busy,
  output logic done
);

  localparam int unsigned WinW  = $clog2(SETTLE_CYC + 1);
  localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned GapW  = GAP_W + 1;

  localparam logic [WinW-1:0]  WinLoad  = WinW'(SETTLE_CYC - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYC - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SeedEff  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {
    StIdle,
    StBounce,
    StHold
  } state_e;

  state_e           state_q, state_d;
  logic             target_q, target_d;
  logic [WinW-1:0]  win_cnt_q, win_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [GapW-1:0]  gap_reload;

  // Gap length 1..2^GAP_W drawn from the LFSR value before this edge's advance.
  assign gap_reload = {1'b0, lfsr_q[GAP_W-1:0]} + GapW'(1);

  // LFSR next value; it free-runs whenever reset is low.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LfsrTaps;
    end
  end

  // Next-state and registered-output logic for IDLE / BOUNCE / HOLD.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    win_cnt_d  = win_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    hold_cnt_d = hold_cnt_q;
    out_d      = out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (in != out_q) begin
          state_d   = StBounce;
          target_d  = in;
          win_cnt_d = WinLoad;
          out_d     = ~out_q;
          gap_cnt_d = gap_reload;
          busy_d    = 1'b1;
        end
      end

      StBounce: begin
        busy_d = 1'b1;
        if (win_cnt_q == '0) begin
          out_d      = target_q;
          hold_cnt_d = HoldLoad;
          state_d    = StHold;
        end else begin
          if (gap_cnt_q == GapW'(1)) begin
            out_d     = ~out_q;
            gap_cnt_d = gap_reload;
          end else begin
            gap_cnt_d = gap_cnt_q - GapW'(1);
          end
          // A new request restarts the window instead of counting it down.
          if (in != target_q) begin
            target_d  = in;
            win_cnt_d = WinLoad;
          end else begin
            win_cnt_d = win_cnt_q - WinW'(1);
          end
        end
      end

      StHold: begin
        busy_d = 1'b1;
        if (hold_cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - HoldW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      target_q   <= 1'b0;
      win_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      hold_cnt_q <= '0;
      lfsr_q     <= SeedEff;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      win_cnt_q  <= win_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      lfsr_q     <= lfsr_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
